i2c_slave_core: RTL and testbench
=================================

Name: i2c_slave_core

Overview:
Bit-level I2C slave engine that sits directly upstream of i2c_frame_bridge. It synchronises the SCL/SDA pins, detects START/STOP and matches the 7-bit slave address. It shifts bytes in and out, drives ACK and read data on SDA through an open-drain enable, and presents byte-level pulses and data to the frame bridge. No clock stretching; system clock must be ≥ 8x SCL.

Parameters:
SLAVE_ADDR, 7'h40, 7-bit address this slave answers to (general call 7'h00 is never matched)
SYNC_STAGES, 2, flops in each SCL/SDA input synchroniser (≥2)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
scl_i  in  1  raw SCL pin
sda_i  in  1  raw SDA pin
sda_oe_o  out  1  1 = pull SDA low (open-drain), 0 = release
i2c_rx_data_o  out  8  last received byte (address byte or write data)
wr_req_o  out  1  1-cycle pulse: write-data byte valid on i2c_rx_data_o
rd_req_o  out  1  1-cycle pulse: i2c_tx_data_i loaded into the TX shifter
wr_allow_i  in  1  1 = ACK the current write byte, 0 = NACK
rd_allow_i  in  1  1 = transmit i2c_tx_data_i, 0 = transmit 8'hFF
i2c_tx_data_i  in  8  byte to transmit on read
rw_bit_o  out  1  R/W bit of the last matched address (1 = read)
addr_match_o  out  1  1-cycle pulse on address match
edge_detect_o  out  1  1-cycle pulse per synchronised SCL rising edge
start_detected_o  out  1  1-cycle pulse on START or repeated START
stop_detected_o  out  1  1-cycle pulse on STOP

Behaviour:
- Reset (rst_i sampled high at clk_i edge): synchronisers and previous-sample flops = 1; state IDLE; every output = 0. Reset mid-transfer releases SDA on the same edge.
- scl_s/sda_s = synchroniser outputs. scl_rise = scl_s & ~scl_q; scl_fall = ~scl_s & scl_q. Pin-to-pulse latency = SYNC_STAGES+1 cycles. edge_detect_o = scl_rise.
- START: sda_s falls while scl_s=scl_q=1. STOP: sda_s rises while SCL high. Both are 1-cycle pulses and are honoured in every state.
  - START → ADDR, bit counter 0, sda_oe_o=0.
  - STOP → IDLE, sda_oe_o=0.
  - START/STOP take priority over any SCL-edge action in the same cycle.
- Bits are sampled on scl_rise, MSB first. SDA is changed only on scl_fall.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- ADDR: shift 8 bits. On the 8th scl_rise, i2c_rx_data_o = address byte.
  - If byte[7:1]==SLAVE_ADDR: pulse addr_match_o, latch rw_bit_o=byte[0], go to ADDR_ACK.
  - Otherwise go to WAIT_STOP.
- ADDR_ACK: next scl_fall sets sda_oe_o=1. The following scl_fall releases SDA (write) and goes to WR_DATA. For a read, the same scl_fall goes to RD_DATA and performs the read load.
- WR_DATA: 8th scl_rise updates i2c_rx_data_o, pulses wr_req_o and captures wr_allow_i as ack flag, then goes to WR_ACK.
- WR_ACK: next scl_fall sets sda_oe_o=ack flag; the following scl_fall releases SDA.
  - ack=1 → WR_DATA, counter 0.
  - ack=0 (NACK) → WAIT_STOP.
- Read load (on entry to RD_DATA): TX shifter = rd_allow_i ? i2c_tx_data_i : 8'hFF; rd_req_o pulses the same cycle; sda_oe_o = ~shifter[7].
  - Each following scl_fall shifts left and drives the next bit.
  - After the 8th bit, the next scl_fall releases SDA and goes to RD_ACK.
- RD_ACK: sample SDA on scl_rise.
  - 0 (master ACK) → next scl_fall performs a read load for the next byte.
  - 1 (NACK) → WAIT_STOP, SDA released.
- WAIT_STOP / IDLE: SDA released; only START/STOP are acted on.
- i2c_rx_data_o and rw_bit_o hold their value until overwritten.

Test Plan:
- Write: START, 0x80 (0x40,W), 0x05, 0x12, 0x34, STOP → addr_match_o pulses once with rw_bit_o=0; three wr_req_o pulses with i2c_rx_data_o=05,12,34; ACK low on all four 9th clocks; stop_detected_o pulses; sda_oe_o=0.
- Address miss: START, 0x82, 0x05 → no addr_match_o, no wr_req_o, SDA never driven; state leaves WAIT_STOP only on START/STOP.
- Repeated-START read: write 0x80, 0x07, then Sr, 0x81, tx data 0xCD then 0xAB, master ACK then NACK, STOP → SDA bits are 0xCD then 0xAB; two rd_req_o pulses; SDA released after the NACK.
- Write NACK: wr_allow_i=0 during byte 2 → 9th bit SDA high; no further wr_req_o until a new START.
- rd_allow_i=0 on read → 0xFF on the bus; rd_req_o still pulses.
- Reset mid-read while sda_oe_o=1 → sda_oe_o=0 on the same edge; all outputs 0; next START+address is handled normally.

Source files
------------

// File: rtl/i2c_slave_core.sv
// i2c_slave_core: bit-level I2C slave engine.
// Synchronises SCL/SDA and detects START/STOP. It matches a 7-bit address,
// then shifts bytes in and out. The byte-level pulses it produces feed the
// frame bridge. SDA is driven only through an open-drain enable, and there is
// no clock stretching.
module i2c_slave_core #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h40,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] i2c_rx_data_o,
  output logic       wr_req_o,
  output logic       rd_req_o,
  input  logic       wr_allow_i,
  input  logic       rd_allow_i,
  input  logic [7:0] i2c_tx_data_i,
  output logic       rw_bit_o,
  output logic       addr_match_o,
  output logic       edge_detect_o,
  output logic       start_detected_o,
  output logic       stop_detected_o
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic       scl_q;
  logic       sda_q;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [6:0] tx_shift;
  logic       ack_flag;
  logic       ack_phase;

  logic       scl_s;
  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_cond;
  logic       stop_cond;
  logic [7:0] rx_byte;
  logic [7:0] load_byte;

  assign scl_s      = scl_sync[SYNC_STAGES-1];
  assign sda_s      = sda_sync[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_q;
  assign scl_fall   = ~scl_s & scl_q;
  assign start_cond = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_cond  = scl_s & scl_q & ~sda_q & sda_s;
  assign rx_byte    = {rx_shift, sda_s};
  assign load_byte  = rd_allow_i ? i2c_tx_data_i : 8'hFF;

  // Pin synchronisers plus one-cycle-delayed copies used for edge detection.
  // They reset to the idle bus level so that reset itself creates no edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  // Protocol FSM. START and STOP override any SCL-edge action in the same
  // cycle. Bits are sampled on SCL rise, and SDA is changed only on SCL fall.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= IDLE;
      bit_cnt          <= 3'd0;
      rx_shift         <= 7'd0;
      tx_shift         <= 7'd0;
      ack_flag         <= 1'b0;
      ack_phase        <= 1'b0;
      sda_oe_o         <= 1'b0;
      i2c_rx_data_o    <= 8'd0;
      wr_req_o         <= 1'b0;
      rd_req_o         <= 1'b0;
      rw_bit_o         <= 1'b0;
      addr_match_o     <= 1'b0;
      edge_detect_o    <= 1'b0;
      start_detected_o <= 1'b0;
      stop_detected_o  <= 1'b0;
    end else begin
      addr_match_o     <= 1'b0;
      wr_req_o         <= 1'b0;
      rd_req_o         <= 1'b0;
      edge_detect_o    <= scl_rise;
      start_detected_o <= start_cond;
      stop_detected_o  <= stop_cond;
      if (start_cond) begin
        state    <= ADDR;
        bit_cnt  <= 3'd0;
        sda_oe_o <= 1'b0;
      end else if (stop_cond) begin
        state    <= IDLE;
        sda_oe_o <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              rx_shift <= rx_byte[6:0];
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                i2c_rx_data_o <= rx_byte;
                if (rx_byte[7:1] == SLAVE_ADDR && rx_byte[7:1] != 7'h00) begin
                  addr_match_o <= 1'b1;
                  rw_bit_o     <= rx_byte[0];
                  ack_phase    <= 1'b0;
                  state        <= ADDR_ACK;
                end else begin
                  state <= WAIT_STOP;
                end
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_oe_o  <= 1'b1;
                ack_phase <= 1'b1;
              end else if (rw_bit_o) begin
                tx_shift <= load_byte[6:0];
                rd_req_o <= 1'b1;
                sda_oe_o <= ~load_byte[7];
                bit_cnt  <= 3'd0;
                state    <= RD_DATA;
              end else begin
                sda_oe_o <= 1'b0;
                bit_cnt  <= 3'd0;
                state    <= WR_DATA;
              end
            end
          end
          WR_DATA: begin
            if (scl_rise) begin
              rx_shift <= rx_byte[6:0];
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                i2c_rx_data_o <= rx_byte;
                wr_req_o      <= 1'b1;
                ack_flag      <= wr_allow_i;
                ack_phase     <= 1'b0;
                state         <= WR_ACK;
              end
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_oe_o  <= ack_flag;
                ack_phase <= 1'b1;
              end else begin
                sda_oe_o <= 1'b0;
                bit_cnt  <= 3'd0;
                state    <= ack_flag ? WR_DATA : WAIT_STOP;
              end
            end
          end
          RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                sda_oe_o <= 1'b0;
                ack_flag <= 1'b0;
                state    <= RD_ACK;
              end else begin
                sda_oe_o <= ~tx_shift[6];
                tx_shift <= {tx_shift[5:0], 1'b0};
                bit_cnt  <= bit_cnt + 3'd1;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                ack_flag <= 1'b1;
              end else begin
                sda_oe_o <= 1'b0;
                state    <= WAIT_STOP;
              end
            end else if (scl_fall && ack_flag) begin
              tx_shift <= load_byte[6:0];
              rd_req_o <= 1'b1;
              sda_oe_o <= ~load_byte[7];
              bit_cnt  <= 3'd0;
              state    <= RD_DATA;
            end
          end
          default: begin
            sda_oe_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_core.sv
// tb_i2c_slave_core: directed bench for i2c_slave_core.
// A behavioural I2C master drives an open-drain bus model. Pulse monitors
// count the DUT's byte-level events for comparison with hand-computed values.
module tb_i2c_slave_core;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       wr_allow = 1'b1;
  logic       rd_allow = 1'b1;
  logic [7:0] tx_data = 8'h00;

  logic       sda_oe;
  logic [7:0] rx_data;
  logic       wr_req;
  logic       rd_req;
  logic       rw_bit;
  logic       addr_match;
  logic       edge_det;
  logic       start_det;
  logic       stop_det;
  logic       sda_bus;

  assign sda_bus = sda_m & ~sda_oe;

  int checks = 0;
  int failures = 0;

  int n_match = 0, n_wr = 0, n_rd = 0, n_start = 0, n_stop = 0, n_edge = 0, n_oe = 0;
  int b_match, b_wr, b_rd, b_start, b_stop, b_edge, b_oe;
  logic [7:0] last_wr = 8'h00;
  logic       last_rw = 1'b0;

  logic       ack;
  logic [7:0] rd_byte;

  i2c_slave_core #(.SLAVE_ADDR(7'h40), .SYNC_STAGES(2)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .scl_i            (scl_m),
    .sda_i            (sda_bus),
    .sda_oe_o         (sda_oe),
    .i2c_rx_data_o    (rx_data),
    .wr_req_o         (wr_req),
    .rd_req_o         (rd_req),
    .wr_allow_i       (wr_allow),
    .rd_allow_i       (rd_allow),
    .i2c_tx_data_i    (tx_data),
    .rw_bit_o         (rw_bit),
    .addr_match_o     (addr_match),
    .edge_detect_o    (edge_det),
    .start_detected_o (start_det),
    .stop_detected_o  (stop_det)
  );

  always #5 clk = ~clk;

  // Count DUT pulses half a cycle away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (addr_match) begin n_match <= n_match + 1; last_rw <= rw_bit; end
      if (wr_req)     begin n_wr <= n_wr + 1; last_wr <= rx_data; end
      if (rd_req)     n_rd <= n_rd + 1;
      if (start_det)  n_start <= n_start + 1;
      if (stop_det)   n_stop <= n_stop + 1;
      if (edge_det)   n_edge <= n_edge + 1;
      if (sda_oe)     n_oe <= n_oe + 1;
    end
  end

  // Hard time limit so a stuck run still terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitQ();
    repeat (Q) @(negedge clk);
  endtask

  task automatic snap();
    b_match = n_match; b_wr = n_wr; b_rd = n_rd; b_start = n_start;
    b_stop = n_stop; b_edge = n_edge; b_oe = n_oe;
  endtask

  // One SCL clock with the master driving bit_in; bit_seen is the bus mid-high.
  task automatic applyStimulus(input logic bit_in, output logic bit_seen);
    sda_m = bit_in; waitQ();
    scl_m = 1'b1;   waitQ();
    bit_seen = sda_bus; waitQ();
    scl_m = 1'b0;   waitQ();
  endtask

  task automatic sendStart();
    sda_m = 1'b1; waitQ();
    scl_m = 1'b1; waitQ();
    sda_m = 1'b0; waitQ();
    scl_m = 1'b0; waitQ();
  endtask

  task automatic sendStop();
    scl_m = 1'b0; sda_m = 1'b0; waitQ();
    scl_m = 1'b1; waitQ();
    sda_m = 1'b1; waitQ();
    repeat (4) @(negedge clk);
  endtask

  task automatic writeByte(input logic [7:0] b, output logic ack_bit);
    logic s;
    for (int i = 7; i >= 0; i--) applyStimulus(b[i], s);
    applyStimulus(1'b1, ack_bit);
  endtask

  task automatic readByte(input logic master_ack, input logic [7:0] next_tx, output logic [7:0] d);
    logic s;
    logic [7:0] tmp;
    tmp = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(1'b1, s);
      tmp[i] = s;
    end
    tx_data = next_tx;
    applyStimulus(~master_ack, s);
    d = tmp;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_sda_oe", sda_oe, 0);
    checkOutput("rst_rx_data", rx_data, 0);
    checkOutput("rst_rw_bit", rw_bit, 0);
    checkOutput("rst_pulses", {addr_match, wr_req, rd_req, edge_det, start_det, stop_det}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Plain write of three bytes
    snap();
    sendStart();
    writeByte(8'h80, ack); checkOutput("wr_addr_ack", ack, 0);
    writeByte(8'h05, ack); checkOutput("wr_b0_ack", ack, 0); checkOutput("wr_b0_data", last_wr, 8'h05);
    writeByte(8'h12, ack); checkOutput("wr_b1_ack", ack, 0); checkOutput("wr_b1_data", last_wr, 8'h12);
    writeByte(8'h34, ack); checkOutput("wr_b2_ack", ack, 0); checkOutput("wr_b2_data", last_wr, 8'h34);
    sendStop();
    checkOutput("wr_match_cnt", n_match - b_match, 1);
    checkOutput("wr_rw_bit", last_rw, 0);
    checkOutput("wr_req_cnt", n_wr - b_wr, 3);
    checkOutput("wr_start_cnt", n_start - b_start, 1);
    checkOutput("wr_stop_cnt", n_stop - b_stop, 1);
    checkOutput("wr_edge_cnt", n_edge - b_edge, 37);
    checkOutput("wr_sda_oe_end", sda_oe, 0);

    // Address miss, then a new START is accepted again
    snap();
    sendStart();
    writeByte(8'h82, ack); checkOutput("miss_addr_nack", ack, 1);
    writeByte(8'h05, ack); checkOutput("miss_data_nack", ack, 1);
    checkOutput("miss_match_cnt", n_match - b_match, 0);
    checkOutput("miss_wr_cnt", n_wr - b_wr, 0);
    checkOutput("miss_oe_cycles", n_oe - b_oe, 0);
    sendStart();
    writeByte(8'h80, ack); checkOutput("miss_restart_ack", ack, 0);
    sendStop();
    checkOutput("miss_start_cnt", n_start - b_start, 2);

    // Write then repeated-START read of two bytes
    snap();
    tx_data = 8'hCD;
    sendStart();
    writeByte(8'h80, ack); checkOutput("rs_waddr_ack", ack, 0);
    writeByte(8'h07, ack); checkOutput("rs_wdata_ack", ack, 0); checkOutput("rs_wdata", last_wr, 8'h07);
    sendStart();
    writeByte(8'h81, ack); checkOutput("rs_raddr_ack", ack, 0);
    checkOutput("rs_rw_bit", last_rw, 1);
    readByte(1'b1, 8'hAB, rd_byte); checkOutput("rs_rd0", rd_byte, 8'hCD);
    readByte(1'b0, 8'h00, rd_byte); checkOutput("rs_rd1", rd_byte, 8'hAB);
    checkOutput("rs_sda_released", sda_oe, 0);
    sendStop();
    checkOutput("rs_rd_cnt", n_rd - b_rd, 2);
    checkOutput("rs_match_cnt", n_match - b_match, 2);
    checkOutput("rs_wr_cnt", n_wr - b_wr, 1);

    // Slave NACKs a write byte and ignores the rest
    snap();
    sendStart();
    writeByte(8'h80, ack); checkOutput("nk_addr_ack", ack, 0);
    writeByte(8'h11, ack); checkOutput("nk_b0_ack", ack, 0);
    wr_allow = 1'b0;
    writeByte(8'h22, ack); checkOutput("nk_b1_nack", ack, 1);
    wr_allow = 1'b1;
    writeByte(8'h33, ack); checkOutput("nk_b2_nack", ack, 1);
    sendStop();
    checkOutput("nk_wr_cnt", n_wr - b_wr, 2);
    checkOutput("nk_last_wr", last_wr, 8'h22);

    // Read with rd_allow low returns 0xFF
    snap();
    rd_allow = 1'b0;
    tx_data = 8'h5A;
    sendStart();
    writeByte(8'h81, ack); checkOutput("ra_addr_ack", ack, 0);
    readByte(1'b0, 8'h5A, rd_byte); checkOutput("ra_data", rd_byte, 8'hFF);
    sendStop();
    checkOutput("ra_rd_cnt", n_rd - b_rd, 1);
    rd_allow = 1'b1;

    // Reset in the middle of a read while SDA is pulled low
    tx_data = 8'h00;
    sendStart();
    writeByte(8'h81, ack); checkOutput("mr_addr_ack", ack, 0);
    checkOutput("mr_oe_before", sda_oe, 1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("mr_oe_same_edge", sda_oe, 0);
    checkOutput("mr_rx_data", rx_data, 0);
    checkOutput("mr_rw_bit", rw_bit, 0);
    checkOutput("mr_pulses", {addr_match, wr_req, rd_req, edge_det, start_det, stop_det}, 0);
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    snap();
    sendStart();
    writeByte(8'h80, ack); checkOutput("mr_new_addr_ack", ack, 0);
    writeByte(8'h99, ack); checkOutput("mr_new_data_ack", ack, 0);
    sendStop();
    checkOutput("mr_match_cnt", n_match - b_match, 1);
    checkOutput("mr_last_wr", last_wr, 8'h99);
    checkOutput("mr_rw_bit_new", last_rw, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
